shift_and_subtract_binary_divider: RTL and testbench

Sequential unsigned restoring divider: the inverse of the shift-and-add multiplier in the same arithmetic library. It accepts a dividend/divisor pair on a start strobe and resolves one quotient bit per clock by shift-and-compare-subtract. It presents the registered quotient and remainder with a one-cycle done pulse. It sits beside the multiplier in the datapath and uses the same clk/rst domain.

---
 rtl/shift_div_pkg.sv | 23 ++
 rtl/shift_sub_step.sv | 32 +++
 rtl/shift_and_subtract_binary_divider.sv | 122 ++++++++++++
 tb/tb_shift_and_subtract_binary_divider.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_div_pkg.sv
// Shared definitions for the shift-and-subtract divider: FSM states,
// default operand width and the counter-width helper.
package shift_div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DIV_W = 8;

  // Number of bits needed to hold values 0..value-1, computed with plain
  // arithmetic so it can size ports and registers at elaboration.
  function automatic int clog2(input int value);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << n) < value) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/shift_sub_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and keep the difference
// when it does not go negative.
module shift_sub_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] r,
  input  logic         d_bit,
  input  logic [W-1:0] v,
  output logic [W-1:0] r_next,
  output logic         q_bit
);

  // The trial value carries one extra bit so the compare against the
  // divisor is exact; the partial remainder itself always stays below the
  // divisor, so W bits are enough to hold it between iterations.
  logic [W:0] trial;

  // Compare-and-subtract for the current quotient bit.
  always_comb begin
    // NOTE: every output gets a value on every path through this block,
    // otherwise synthesis infers a latch to hold the missing case.
    trial  = {r, d_bit};
    q_bit  = 1'b0;
    r_next = trial[W-1:0];
    if (trial >= {1'b0, v}) begin
      q_bit  = 1'b1;
      r_next = W'(trial - {1'b0, v});
    end
  end

endmodule

// File: rtl/shift_and_subtract_binary_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// A start strobe in IDLE captures the operands; W cycles later the
// registered quotient and remainder appear together with a done pulse.
// Optional build macro SHIFT_SUB_DIV_ZERO_CHECK_EN: a zero divisor
// finishes one cycle after accept and raises div_by_zero.
module shift_and_subtract_binary_divider
  import shift_div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CNT_W = clog2(W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

  state_t           state;
  logic [W-1:0]     d_q;     // dividend shifting out, quotient shifting in
  logic [W-1:0]     v_q;     // captured divisor
  logic [W-1:0]     r_q;     // partial remainder
  logic [CNT_W-1:0] cnt_q;   // iterations completed

  logic [W-1:0] r_next;
  logic         q_bit;
  logic [W-1:0] d_next;
  logic         take_zero;   // finish immediately on a zero divisor

  shift_sub_step #(.W(W)) u_step (
    .r      (r_q),
    .d_bit  (d_q[W-1]),
    .v      (v_q),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  assign d_next = {d_q[W-2:0], q_bit};

`ifdef SHIFT_SUB_DIV_ZERO_CHECK_EN
  logic zero_q;
  logic dz_q;

  assign take_zero   = zero_q;
  assign div_by_zero = dz_q;

  // Remember a zero divisor at accept and report it at completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      if (state == IDLE && start) zero_q <= (divisor == '0);
      if (state == RUN && (zero_q || cnt_q == LAST)) dz_q <= zero_q;
    end
  end
`else
  assign take_zero   = 1'b0;
  assign div_by_zero = 1'b0;
`endif

  // Control FSM, iteration datapath and registered results.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the values from before this edge.
    if (rst) begin
      state     <= IDLE;
      d_q       <= '0;
      v_q       <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            d_q   <= dividend;
            v_q   <= divisor;
            r_q   <= '0;
            cnt_q <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (take_zero) begin
            // Dividing by zero: all-ones quotient, dividend as remainder.
            quotient  <= '1;
            remainder <= d_q;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            d_q   <= d_next;
            r_q   <= r_next;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              quotient  <= d_next;
              remainder <= r_next;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_and_subtract_binary_divider.sv
// Self-checking bench for the shift-and-subtract divider: a W=8 instance
// for directed and random cases and a W=4 instance for an exhaustive sweep.
// Expected results come from plain integer division and are queued at
// issue time; monitors pop and compare whenever done is seen.
module tb_shift_and_subtract_binary_divider;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dz;
    int due;
  } exp_t;

  logic clk;
  logic rst;

  logic       start8, busy8, done8, dz8;
  logic [7:0] dividend8, divisor8, q8, r8;
  logic       start4, busy4, done4, dz4;
  logic [3:0] dividend4, divisor4, q4, r4;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb8[$];
  exp_t sb4[$];
  exp_t e8, e4;

  shift_and_subtract_binary_divider #(.W(8)) dut8 (
    .clk         (clk),
    .rst         (rst),
    .start       (start8),
    .dividend    (dividend8),
    .divisor     (divisor8),
    .busy        (busy8),
    .done        (done8),
    .quotient    (q8),
    .remainder   (r8),
    .div_by_zero (dz8)
  );

  shift_and_subtract_binary_divider #(.W(4)) dut4 (
    .clk         (clk),
    .rst         (rst),
    .start       (start4),
    .dividend    (dividend4),
    .divisor     (divisor4),
    .busy        (busy4),
    .done        (done4),
    .quotient    (q4),
    .remainder   (r4),
    .div_by_zero (dz4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: unsigned integer division; a zero divisor yields all ones
  // and the dividend, early only when the zero check is built in.
  function automatic exp_t model(input int a, input int b, input int w, input int accept);
    exp_t e;
    int   lat;
    e.a = a;
    e.b = b;
    lat = w;
    if (b == 0) begin
      e.q = (1 << w) - 1;
      e.r = a;
`ifdef SHIFT_SUB_DIV_ZERO_CHECK_EN
      e.dz = 1;
      lat  = 1;
`else
      e.dz = 0;
`endif
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 0;
    end
    e.due = accept + lat;
    return e;
  endfunction

  // Called at a falling edge; waits for idle, presents one request.
  task automatic issue8(input int a, input int b, input bit push);
    int n = 0;
    while (busy8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy8) check("idle_wait8", busy8, 0);
    start8    = 1'b1;
    dividend8 = 8'(a);
    divisor8  = 8'(b);
    if (push) sb8.push_back(model(a, b, 8, cyc + 1));
    @(negedge clk);
    start8 = 1'b0;
    check("busy_after_accept8", busy8, 1);
  endtask

  task automatic issue4(input int a, input int b);
    int n = 0;
    while (busy4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy4) check("idle_wait4", busy4, 0);
    start4    = 1'b1;
    dividend4 = 4'(a);
    divisor4  = 4'(b);
    sb4.push_back(model(a, b, 4, cyc + 1));
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic wait_done8();
    int n = 0;
    while (!done8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!done8) check("done_timeout8", done8, 1);
  endtask

  // Monitor for the W=8 instance.
  always @(negedge clk) begin
    if (!rst && done8) begin
      check("pending8", 32'(sb8.size() > 0), 1);
      if (sb8.size() > 0) begin
        e8 = sb8.pop_front();
        check("quotient8", q8, e8.q);
        check("remainder8", r8, e8.r);
        check("div_by_zero8", dz8, e8.dz);
        check("latency8", cyc, e8.due);
        check("busy_at_done8", busy8, 0);
      end
    end
  end

  // Monitor for the W=4 instance, with the division identity on top.
  always @(negedge clk) begin
    if (!rst && done4) begin
      check("pending4", 32'(sb4.size() > 0), 1);
      if (sb4.size() > 0) begin
        e4 = sb4.pop_front();
        check("quotient4", q4, e4.q);
        check("remainder4", r4, e4.r);
        check("div_by_zero4", dz4, e4.dz);
        check("latency4", cyc, e4.due);
        check("identity4", 32'(int'(q4) * e4.b + int'(r4)), e4.a);
        check("rem_below_div4", 32'(int'(r4) < e4.b), 1);
      end
    end
  end

  initial begin
    int n;
    rst       = 1'b1;
    start8    = 1'b0;
    dividend8 = '0;
    divisor8  = '0;
    start4    = 1'b0;
    dividend4 = '0;
    divisor4  = '0;
    #1;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_quotient", q8, 0);
    check("rst_remainder", r8, 0);
    check("rst_dz", dz8, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic case.
    issue8(100, 7, 1);
    wait_done8();
    @(negedge clk);
    check("done_one_cycle", done8, 0);
    check("quotient_held", q8, 14);
    check("remainder_held", r8, 2);

    // Back-to-back: second start lands in the first done cycle.
    issue8(255, 1, 1);
    wait_done8();
    issue8(5, 9, 1);
    wait_done8();
    @(negedge clk);

    // Zero divisor.
    issue8(200, 0, 1);
    wait_done8();
    @(negedge clk);

    // Starts while busy are ignored.
    issue8(100, 7, 1);
    @(negedge clk);
    start8 = 1'b1; dividend8 = 8'd50; divisor8 = 8'd3;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    start8 = 1'b1; dividend8 = 8'd60; divisor8 = 8'd4;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8();
    repeat (12) @(negedge clk);
    check("no_extra_done", done8, 0);

    // Reset in the middle of a run, then a fresh operation.
    issue8(100, 7, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_quotient", q8, 0);
    check("abort_remainder", r8, 0);
    check("abort_dz", dz8, 0);
    @(negedge clk);
    rst = 1'b0;
    issue8(9, 3, 1);
    wait_done8();
    @(negedge clk);

    // Random operands, occasional zero divisor.
    for (int i = 0; i < 40; i++) begin
      int a, b;
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      issue8(a, b, 1);
    end

    // Exhaustive W=4 sweep over non-zero divisors.
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        issue4(a, b);
      end
    end

    n = 0;
    while ((sb8.size() != 0 || sb4.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb8.size() + sb4.size()), 0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
